// File: rtl/switch_event_arbiter.sv
// Turns debounced switch rising edges into ASCII bytes and shares the single
// UART transmitter between switches with a round-robin grant.
module switch_event_arbiter #(
    parameter int         NUM_SW    = 4,
    parameter logic [7:0] BASE_CHAR = 8'h31
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [NUM_SW-1:0] i_Switch,
    input  logic              i_TX_Active,
    input  logic              i_TX_Done,
    output logic              o_TX_DV,
    output logic [7:0]        o_TX_Byte,
    output logic [NUM_SW-1:0] o_Pending,
    output logic [NUM_SW-1:0] o_Overrun,
    output logic              o_Busy
);
    localparam int PTR_W  = $clog2(NUM_SW);
    localparam int CAND_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state;
    state_t            state_next;
    logic [NUM_SW-1:0] r_prev;
    logic              r_armed;
    logic [PTR_W-1:0]  r_ptr;
    logic [NUM_SW-1:0] rise;
    logic [NUM_SW-1:0] grant_mask;
    logic [PTR_W-1:0]  grant_idx;
    logic [CAND_W-1:0] cand;
    logic              found;
    logic              do_grant;

    // The first clock after reset only primes r_prev, so levels already high are ignored
    assign rise = i_Switch & ~r_prev & {NUM_SW{r_armed}};

    // Search pending flags starting at r_ptr, wrapping around the switch count
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_SW; k++) begin
            cand = {1'b0, r_ptr} + CAND_W'(k);
            if (cand >= CAND_W'(NUM_SW)) begin
                cand = cand - CAND_W'(NUM_SW);
            end
            if (!found && o_Pending[cand[PTR_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        case (state)
            IDLE: begin
                if (found && !i_TX_Active) begin
                    do_grant   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (i_TX_Done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign grant_mask = do_grant ? (NUM_SW'(1) << grant_idx) : '0;
    assign o_TX_DV    = (state == ISSUE);
    assign o_Busy     = (state != IDLE);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A re-press on the grant cycle is a fresh event, not a lost one
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_prev    <= '0;
            r_armed   <= 1'b0;
            r_ptr     <= '0;
            o_TX_Byte <= 8'h00;
            o_Pending <= '0;
            o_Overrun <= '0;
        end else begin
            r_prev    <= i_Switch;
            r_armed   <= 1'b1;
            o_Pending <= (o_Pending & ~grant_mask) | rise;
            o_Overrun <= o_Overrun | (rise & o_Pending & ~grant_mask);
            if (do_grant) begin
                o_TX_Byte <= BASE_CHAR + 8'(grant_idx);
                r_ptr     <= (grant_idx == PTR_W'(NUM_SW - 1)) ? '0 : grant_idx + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_switch_event_arbiter.sv
// Directed self-checking bench for switch_event_arbiter with NUM_SW=4 and
// BASE_CHAR=8'h31; expected bytes and flags are worked out by hand.
module tb_switch_event_arbiter;
    logic       i_Clk;
    logic       i_Rst_L;
    logic [3:0] i_Switch;
    logic       i_TX_Active;
    logic       i_TX_Done;
    logic       o_TX_DV;
    logic [7:0] o_TX_Byte;
    logic [3:0] o_Pending;
    logic [3:0] o_Overrun;
    logic       o_Busy;

    int compared   = 0;
    int mismatched = 0;

    switch_event_arbiter #(
        .NUM_SW   (4),
        .BASE_CHAR(8'h31)
    ) dut (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .i_Switch   (i_Switch),
        .i_TX_Active(i_TX_Active),
        .i_TX_Done  (i_TX_Done),
        .o_TX_DV    (o_TX_DV),
        .o_TX_Byte  (o_TX_Byte),
        .o_Pending  (o_Pending),
        .o_Overrun  (o_Overrun),
        .o_Busy     (o_Busy)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] sw, input logic active);
        i_Switch    = sw;
        i_TX_Active = active;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a DV pulse, checks the byte, holds WAIT, then completes it
    task automatic expectByte(input logic [7:0] exp, input string tag);
        int n;
        n = 0;
        while (o_TX_DV !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checkOutput({tag, "_dv"}, 32'(o_TX_DV), 32'd1);
        checkOutput({tag, "_byte"}, 32'(o_TX_Byte), 32'(exp));
        tick();
        tick();
        tick();
        checkOutput({tag, "_wait_dv"}, 32'(o_TX_DV), 32'd0);
        checkOutput({tag, "_wait_byte"}, 32'(o_TX_Byte), 32'(exp));
        i_TX_Done = 1'b1;
        tick();
        i_TX_Done = 1'b0;
        checkOutput({tag, "_idle"}, 32'(o_Busy), 32'd0);
    endtask

    initial begin
        int saw_dv;
        i_Rst_L     = 1'b0;
        i_TX_Done   = 1'b0;
        applyStimulus(4'b1111, 1'b0);
        tick();
        tick();
        checkOutput("rst_dv", 32'(o_TX_DV), 32'd0);
        checkOutput("rst_byte", 32'(o_TX_Byte), 32'h00);
        checkOutput("rst_pending", 32'(o_Pending), 32'd0);
        checkOutput("rst_overrun", 32'(o_Overrun), 32'd0);
        checkOutput("rst_busy", 32'(o_Busy), 32'd0);

        // Switches held high through reset release must stay silent
        i_Rst_L = 1'b1;
        saw_dv  = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (o_TX_DV === 1'b1) saw_dv++;
        end
        checkOutput("held_no_dv", 32'(saw_dv), 32'd0);
        checkOutput("held_no_pending", 32'(o_Pending), 32'd0);
        applyStimulus(4'b0000, 1'b0);
        tick();
        tick();
        checkOutput("release_no_pending", 32'(o_Pending), 32'd0);

        $display("[TB] round-robin 0,1,3");
        applyStimulus(4'b1011, 1'b0);
        tick();
        checkOutput("rr_pending", 32'(o_Pending), 32'hB);
        expectByte(8'h31, "rr_a");
        expectByte(8'h32, "rr_b");
        expectByte(8'h34, "rr_c");
        applyStimulus(4'b0000, 1'b0);
        tick();
        applyStimulus(4'b1001, 1'b0);
        tick();
        checkOutput("rr2_pending", 32'(o_Pending), 32'h9);
        expectByte(8'h31, "rr2_a");
        expectByte(8'h34, "rr2_b");

        $display("[TB] single press latency");
        applyStimulus(4'b0000, 1'b0);
        tick();
        applyStimulus(4'b0100, 1'b0);
        tick();
        checkOutput("sp_pending", 32'(o_Pending), 32'h4);
        checkOutput("sp_dv_early", 32'(o_TX_DV), 32'd0);
        tick();
        checkOutput("sp_dv", 32'(o_TX_DV), 32'd1);
        checkOutput("sp_byte", 32'(o_TX_Byte), 32'h33);
        checkOutput("sp_cleared", 32'(o_Pending), 32'd0);
        tick();
        checkOutput("sp_dv_once", 32'(o_TX_DV), 32'd0);
        checkOutput("sp_busy", 32'(o_Busy), 32'd1);
        i_TX_Done = 1'b1;
        tick();
        i_TX_Done = 1'b0;
        checkOutput("sp_idle", 32'(o_Busy), 32'd0);

        $display("[TB] overrun under stall");
        applyStimulus(4'b0010, 1'b1);
        tick();
        tick();
        tick();
        checkOutput("ov_stall_dv", 32'(o_TX_DV), 32'd0);
        checkOutput("ov_stall_busy", 32'(o_Busy), 32'd0);
        applyStimulus(4'b0000, 1'b1);
        tick();
        applyStimulus(4'b0010, 1'b1);
        tick();
        checkOutput("ov_flag", 32'(o_Overrun), 32'h2);
        checkOutput("ov_pending", 32'(o_Pending), 32'h2);
        applyStimulus(4'b0010, 1'b0);
        expectByte(8'h32, "ov_send");
        saw_dv = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (o_TX_DV === 1'b1) saw_dv++;
        end
        checkOutput("ov_single_send", 32'(saw_dv), 32'd0);

        $display("[TB] re-press on grant cycle");
        applyStimulus(4'b0001, 1'b1);
        tick();
        applyStimulus(4'b0000, 1'b1);
        tick();
        applyStimulus(4'b0001, 1'b0);
        tick();
        checkOutput("rp_dv", 32'(o_TX_DV), 32'd1);
        checkOutput("rp_pending", 32'(o_Pending), 32'h1);
        checkOutput("rp_overrun", 32'(o_Overrun), 32'h2);
        expectByte(8'h31, "rp_first");
        expectByte(8'h31, "rp_second");
        checkOutput("rp_drained", 32'(o_Pending), 32'd0);

        $display("[TB] reset during WAIT");
        applyStimulus(4'b0100, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("mr_busy", 32'(o_Busy), 32'd1);
        #2;
        i_Rst_L = 1'b0;
        #1;
        checkOutput("mr_dv", 32'(o_TX_DV), 32'd0);
        checkOutput("mr_byte", 32'(o_TX_Byte), 32'h00);
        checkOutput("mr_pending", 32'(o_Pending), 32'd0);
        checkOutput("mr_overrun", 32'(o_Overrun), 32'd0);
        checkOutput("mr_busy_low", 32'(o_Busy), 32'd0);
        tick();
        tick();
        i_Rst_L = 1'b1;
        saw_dv  = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (o_TX_DV === 1'b1) saw_dv++;
        end
        checkOutput("mr_no_dv", 32'(saw_dv), 32'd0);
        checkOutput("mr_no_pending", 32'(o_Pending), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
